// File: rtl/shared_ram_pkg.sv
// Shared types and widths for the two-port Wishbone arbiter in front of the
// 256 x 32 single-port RAM macro.
package shared_ram_pkg;
  localparam int RAM_AW = 8;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;
endpackage

// File: rtl/wb_rr_arbiter2.sv
// Two-requester round-robin arbiter. Grants are combinational and only
// produced while enabled; the last winner is remembered to break ties.
module wb_rr_arbiter2
  import shared_ram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic grant_a,
  output logic grant_b
);
  port_e last_grant_q;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        grant_a = (last_grant_q == PORT_B);
        grant_b = (last_grant_q == PORT_A);
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
  end

  // Starts as PORT_B so that A wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= PORT_B;
    end else if (grant_a) begin
      last_grant_q <= PORT_A;
    end else if (grant_b) begin
      last_grant_q <= PORT_B;
    end
  end
endmodule

// File: rtl/shared_ram_arbiter.sv
// Arbitrates Caravel (A) and RAMBus (B) Wishbone ports onto the single RW
// port of the RAM macro; one access per 4 cycles, ack 3 cycles after request.
module shared_ram_arbiter #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          RAM_AW       = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              a_stb_i,
  input  logic              a_cyc_i,
  input  logic              a_we_i,
  input  logic [3:0]        a_sel_i,
  input  logic [31:0]       a_adr_i,
  input  logic [31:0]       a_dat_i,
  output logic              a_ack_o,
  output logic [31:0]       a_dat_o,
  input  logic              b_stb_i,
  input  logic              b_cyc_i,
  input  logic              b_we_i,
  input  logic [3:0]        b_sel_i,
  input  logic [RAM_AW+1:0] b_adr_i,
  input  logic [31:0]       b_dat_i,
  output logic              b_ack_o,
  output logic [31:0]       b_dat_o,
  output logic              ram_csb0_o,
  output logic              ram_web0_o,
  output logic [3:0]        ram_wmask0_o,
  output logic [RAM_AW-1:0] ram_addr0_o,
  output logic [31:0]       ram_din0_o,
  input  logic [31:0]       ram_dout0_i,
  output logic [1:0]        dbg_state_o
);
  import shared_ram_pkg::*;

  // Handshake: a port requests while cyc & stb are high and holds the request
  // until it sees ack, a single-cycle pulse; dropping cyc mid-access aborts it.
  state_e              state_q, state_d;
  port_e               port_q;
  logic                we_q, abort_q, abort_d;
  logic                a_req, b_req, grant_a, grant_b, gnt_cyc;
  logic                pick_we;
  logic [SEL_W-1:0]    pick_sel;
  logic [RAM_AW-1:0]   pick_adr;
  logic [DATA_W-1:0]   pick_dat;
  logic                unused_adr_bits;

  assign a_req = a_cyc_i & a_stb_i & (a_adr_i[31:10] == BASE_ADDRESS[31:10]);
  assign b_req = b_cyc_i & b_stb_i;
  assign unused_adr_bits = ^{a_adr_i[1:0], b_adr_i[1:0]};

  wb_rr_arbiter2 u_arb (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .en      (state_q == IDLE),
    .req_a   (a_req),
    .req_b   (b_req),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign pick_we  = grant_a ? a_we_i : b_we_i;
  assign pick_sel = grant_a ? a_sel_i : b_sel_i;
  assign pick_adr = grant_a ? a_adr_i[RAM_AW+1:2] : b_adr_i[RAM_AW+1:2];
  assign pick_dat = grant_a ? a_dat_i : b_dat_i;
  assign gnt_cyc  = (port_q == PORT_A) ? a_cyc_i : b_cyc_i;
  assign dbg_state_o = state_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (grant_a || grant_b) state_d = ISSUE;
      end
      ISSUE: begin
        if (!gnt_cyc) abort_d = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: state_d = (abort_q || !gnt_cyc) ? IDLE : ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM drive registers are loaded at grant so csb0 is low during ISSUE.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      port_q       <= PORT_A;
      we_q         <= 1'b0;
      a_ack_o      <= 1'b0;
      b_ack_o      <= 1'b0;
      a_dat_o      <= '0;
      b_dat_o      <= '0;
      ram_csb0_o   <= 1'b1;
      ram_web0_o   <= 1'b1;
      ram_wmask0_o <= '0;
      ram_addr0_o  <= '0;
      ram_din0_o   <= '0;
    end else begin
      a_ack_o <= 1'b0;
      b_ack_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_a || grant_b) begin
            port_q       <= grant_a ? PORT_A : PORT_B;
            we_q         <= pick_we;
            ram_csb0_o   <= 1'b0;
            ram_web0_o   <= ~pick_we;
            ram_wmask0_o <= pick_we ? pick_sel : {SEL_W{1'b1}};
            ram_addr0_o  <= pick_adr;
            ram_din0_o   <= pick_dat;
          end
        end
        ISSUE: begin
          ram_csb0_o <= 1'b1;
          ram_web0_o <= 1'b1;
        end
        CAPTURE: begin
          if (!we_q) begin
            if (port_q == PORT_A) a_dat_o <= ram_dout0_i;
            else                  b_dat_o <= ram_dout0_i;
          end
          if (state_d == ACK) begin
            if (port_q == PORT_A) a_ack_o <= 1'b1;
            else                  b_ack_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
